// File: rtl/programmable_sample_clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : programmable_sample_clock_divider_if
// Purpose  : Control/strobe bundle of the programmable sample clock divider.
//            The master side requests a divisor and enables the divider.
//            The slave side (the divider) returns the sample strobes and status.
// Signals  : enable       master -> slave   run the divider
//            div_load     master -> slave   1-cycle divisor capture strobe
//            div_value    master -> slave   requested clocks per sample
//            sample_now   slave  -> master  1-cycle tick per sample period
//            sample_early slave  -> master  1-cycle tick LEAD clocks earlier
//            phase        slave  -> master  current count
//            div_active   slave  -> master  divisor currently in use
//            load_pending slave  -> master  divisor waiting for the boundary
//            sample_count slave  -> master  sample_now ticks, modulo 2^SCNT_W
// Revision : 1.0 - initial release
// ============================================================================
interface programmable_sample_clock_divider_if #(
    parameter int CNT_W  = 16,
    parameter int SCNT_W = 8
);
    logic              enable;
    logic              div_load;
    logic [CNT_W-1:0]  div_value;
    logic              sample_now;
    logic              sample_early;
    logic [CNT_W-1:0]  phase;
    logic [CNT_W-1:0]  div_active;
    logic              load_pending;
    logic [SCNT_W-1:0] sample_count;

    modport master (
        output enable, div_load, div_value,
        input  sample_now, sample_early, phase, div_active, load_pending,
               sample_count
    );

    modport slave (
        input  enable, div_load, div_value,
        output sample_now, sample_early, phase, div_active, load_pending,
               sample_count
    );
endinterface
`default_nettype wire

// File: rtl/programmable_sample_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : programmable_sample_clock_divider
// Purpose  : Sample-rate strobe generator with a run-time divisor. Emits
//            sample_now every div_active clocks and sample_early LEAD clocks
//            before it. A new divisor is shadow-buffered and applied only at
//            a period boundary so the rate changes glitch-free.
// Ports    : clk  in   system clock, rising edge
//            rst  in   synchronous, active-high reset
//            bus  slave modport of programmable_sample_clock_divider_if
//                 (enable/div_load/div_value in; strobes, phase, div_active,
//                 load_pending, sample_count out)
// Revision : 1.0 - initial release
// ============================================================================
module programmable_sample_clock_divider #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 256,
    parameter int LEAD        = 1,
    parameter int SCNT_W      = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    programmable_sample_clock_divider_if.slave bus
);
    // Smallest usable divisor: keeps div_active-1-LEAD from underflowing.
    localparam logic [CNT_W-1:0] c_min_div     = CNT_W'(LEAD + 1);
    localparam logic [CNT_W-1:0] c_lead        = CNT_W'(LEAD);
    localparam logic [CNT_W-1:0] c_default_raw = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_default_div =
        (c_default_raw < c_min_div) ? c_min_div : c_default_raw;

    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_div_active;
    logic [CNT_W-1:0]  r_pending;
    logic              r_load_pending;
    logic [SCNT_W-1:0] r_sample_count;

    logic [CNT_W-1:0]  w_div_m1;
    logic [CNT_W-1:0]  w_clamped;
    logic              w_at_end;
    logic              w_boundary;
    logic              w_apply;

    assign w_div_m1  = r_div_active - 1'b1;
    assign w_clamped = (bus.div_value < c_min_div) ? c_min_div : bus.div_value;
    // ">=" rather than "==" so the counter can never run past the period end.
    assign w_at_end   = (r_count >= w_div_m1);
    assign w_boundary = bus.enable && w_at_end;
    // While disabled the count is parked at 0, so every edge acts as a boundary
    // and any requested divisor is applied immediately.
    assign w_apply    = w_boundary || !bus.enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (!bus.enable || w_at_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_active   <= c_default_div;
            r_pending      <= c_default_div;
            r_load_pending <= 1'b0;
        end else if (w_apply) begin
            // A load in the boundary cycle itself wins over the shadow value.
            if (bus.div_load) begin
                r_div_active <= w_clamped;
            end else if (r_load_pending) begin
                r_div_active <= r_pending;
            end
            r_load_pending <= 1'b0;
        end else if (bus.div_load) begin
            r_pending      <= w_clamped;
            r_load_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_count <= '0;
        end else if (w_boundary) begin
            r_sample_count <= r_sample_count + 1'b1;
        end
    end

    assign bus.sample_now   = w_boundary;
    assign bus.sample_early = bus.enable && (r_count == (w_div_m1 - c_lead));
    assign bus.phase        = r_count;
    assign bus.div_active   = r_div_active;
    assign bus.load_pending = r_load_pending;
    assign bus.sample_count = r_sample_count;
endmodule
`default_nettype wire
